// File: rtl/fm_guard_decode.sv
// rtl/fm_guard_decode.sv - rebuild 6x8 feature-map vectors from guard map + compacted byte stream
// Optional FM_GUARD_DECODE_STAT_EN: adds zero_vec_cnt_o, a saturating per-job count of all-zero guards.
`timescale 1ns/1ps
module fm_guard_decode #(
  parameter int FM_GUARD_GEN_PSUM_BUF_DEPTH = 64,
  parameter int LANES = 6,
  localparam int AW = $clog2(FM_GUARD_GEN_PSUM_BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic                  ctrl_finish,
  input  logic [AW-1:0]         stop_addr_i,
  input  logic                  is_diff_i,
  input  logic [LANES-1:0]      guard_i,
  input  logic                  guard_i_valid,
  output logic                  guard_i_ready,
  input  logic [7:0]            byte_i,
  input  logic                  byte_i_valid,
  output logic                  byte_i_ready,
  output logic [LANES-1:0][7:0] data_o,
  output logic [AW-1:0]         addr_o,
  output logic                  part_o,
  output logic                  data_o_valid,
  input  logic                  data_o_ready
`ifdef FM_GUARD_DECODE_STAT_EN
  ,
  output logic [15:0]           zero_vec_cnt_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_GUARD, S_BYTE, S_PACK, S_EMIT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [AW-1:0]          r_stop;
  logic                   r_diff;
  logic [AW-1:0]          r_addr;
  logic                   r_part;
  logic [LANES-1:0]       r_mask;
  logic [LANES-1:0][7:0]  r_data;
  logic [1:0]             r_pcnt;
  logic                   r_finish;
  logic [2:0]             w_hi;
  logic [LANES-1:0]       w_mask_nxt;
  logic                   w_last;

  // Highest pending lane wins: bytes fill lanes 5 down to 0.
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_mask[i]) w_hi = i[2:0];
    end
  end

  assign w_mask_nxt = r_mask & ~(LANES'(1) << w_hi);
  assign w_last     = (r_addr == r_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    ctrl_ready    = 1'b0;
    guard_i_ready = 1'b0;
    byte_i_ready  = 1'b0;
    data_o_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        ctrl_ready = 1'b1;
        if (ctrl_valid) w_state_nxt = S_GUARD;
      end
      S_GUARD: begin
        guard_i_ready = 1'b1;
        if (guard_i_valid) w_state_nxt = (guard_i == '0) ? S_EMIT : S_BYTE;
      end
      S_BYTE: begin
        byte_i_ready = 1'b1;
        if (byte_i_valid && (w_mask_nxt == '0)) w_state_nxt = S_EMIT;
      end
      S_PACK: begin
        byte_i_ready = 1'b1;
        if (byte_i_valid && (r_pcnt == 2'd2)) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        data_o_valid = 1'b1;
        if (data_o_ready) begin
          if (!w_last)                w_state_nxt = r_part ? S_PACK : S_GUARD;
          else if (r_diff && !r_part) w_state_nxt = S_PACK;
          else                        w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stop   <= '0;
      r_diff   <= 1'b0;
      r_addr   <= '0;
      r_part   <= 1'b0;
      r_mask   <= '0;
      r_data   <= '0;
      r_pcnt   <= 2'd0;
      r_finish <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctrl_valid) begin
            r_stop <= stop_addr_i;
            r_diff <= is_diff_i;
            r_addr <= '0;
            r_part <= 1'b0;
          end
        end
        S_GUARD: begin
          if (guard_i_valid) begin
            r_mask <= guard_i;
            r_data <= '0;
          end
        end
        S_BYTE: begin
          if (byte_i_valid) begin
            r_data[w_hi] <= byte_i;
            r_mask       <= w_mask_nxt;
          end
        end
        S_PACK: begin
          // Nibble pass: high nibble goes to the higher lane of each pair.
          if (byte_i_valid) begin
            case (r_pcnt)
              2'd0: begin
                r_data[5] <= {4'h0, byte_i[7:4]};
                r_data[4] <= {4'h0, byte_i[3:0]};
              end
              2'd1: begin
                r_data[3] <= {4'h0, byte_i[7:4]};
                r_data[2] <= {4'h0, byte_i[3:0]};
              end
              default: begin
                r_data[1] <= {4'h0, byte_i[7:4]};
                r_data[0] <= {4'h0, byte_i[3:0]};
              end
            endcase
            r_pcnt <= (r_pcnt == 2'd2) ? 2'd0 : r_pcnt + 2'd1;
          end
        end
        S_EMIT: begin
          if (data_o_ready) begin
            if (!w_last) begin
              r_addr <= r_addr + AW'(1);
            end else if (r_diff && !r_part) begin
              r_addr <= '0;
              r_part <= 1'b1;
            end else begin
              r_finish <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ctrl_finish = r_finish;
  assign data_o      = r_data;
  assign addr_o      = r_addr;
  assign part_o      = r_part;

`ifdef FM_GUARD_DECODE_STAT_EN
  logic [15:0] r_zcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zcnt <= 16'h0000;
    end else if ((r_state == S_IDLE) && ctrl_valid) begin
      r_zcnt <= 16'h0000;
    end else if ((r_state == S_GUARD) && guard_i_valid && (guard_i == '0) && (r_zcnt != 16'hFFFF)) begin
      r_zcnt <= r_zcnt + 16'h0001;
    end
  end

  assign zero_vec_cnt_o = r_zcnt;
`endif

endmodule

// File: tb/tb_fm_guard_decode.sv
// tb/tb_fm_guard_decode.sv - table-driven and scoreboard bench for fm_guard_decode
`timescale 1ns/1ps
module tb_fm_guard_decode;

  localparam int AW = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ctrl_valid = 1'b0;
  logic             ctrl_ready;
  logic             ctrl_finish;
  logic [AW-1:0]    stop_addr_i = '0;
  logic             is_diff_i = 1'b0;
  logic [5:0]       guard_i = '0;
  logic             guard_i_valid = 1'b0;
  logic             guard_i_ready;
  logic [7:0]       byte_i = '0;
  logic             byte_i_valid = 1'b0;
  logic             byte_i_ready;
  logic [5:0][7:0]  data_o;
  logic [AW-1:0]    addr_o;
  logic             part_o;
  logic             data_o_valid;
  logic             data_o_ready = 1'b1;
`ifdef FM_GUARD_DECODE_STAT_EN
  logic [15:0]      zero_vec_cnt_o;
`endif

  fm_guard_decode #(.FM_GUARD_GEN_PSUM_BUF_DEPTH(64), .LANES(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_finish(ctrl_finish),
    .stop_addr_i(stop_addr_i), .is_diff_i(is_diff_i),
    .guard_i(guard_i), .guard_i_valid(guard_i_valid), .guard_i_ready(guard_i_ready),
    .byte_i(byte_i), .byte_i_valid(byte_i_valid), .byte_i_ready(byte_i_ready),
    .data_o(data_o), .addr_o(addr_o), .part_o(part_o),
    .data_o_valid(data_o_valid), .data_o_ready(data_o_ready)
`ifdef FM_GUARD_DECODE_STAT_EN
    , .zero_vec_cnt_o(zero_vec_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0]   d;
    logic [AW-1:0] a;
    logic          p;
  } vec_t;

  typedef struct packed {
    logic [5:0]      g;
    logic [5:0][7:0] b;
    logic [2:0]      nb;
    logic [47:0]     exp;
  } rec_t;

  typedef struct packed {
    logic [2:0][7:0] b;
    logic [47:0]     exp;
  } pk_t;

  vec_t       sb[$];
  logic [5:0] gq[$];
  logic [7:0] bq[$];
  rec_t       tab[6];
  pk_t        ptab[2];
  vec_t       mon_e;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_hs = -10;
  int         fin_cnt = 0;
  int         gap_max = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every handshaked vector must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (rst_n && data_o_valid && data_o_ready) begin
      last_hs = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_vec", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("vec_data", 64'(data_o), 64'(mon_e.d));
        chk("vec_addr", 64'(addr_o), 64'(mon_e.a));
        chk("vec_part", 64'(part_o), 64'(mon_e.p));
      end
    end
    if (ctrl_finish) fin_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_guard(input logic [5:0] g);
    int t = 0;
    guard_i = g;
    guard_i_valid = 1'b1;
    @(negedge clk);
    while (!guard_i_ready && t < 300) begin @(negedge clk); t++; end
    if (!guard_i_ready) chk("guard_timeout", 64'd0, 64'd1);
    tick();
    guard_i_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_i = b;
    byte_i_valid = 1'b1;
    @(negedge clk);
    while (!byte_i_ready && t < 300) begin @(negedge clk); t++; end
    if (!byte_i_ready) chk("byte_timeout", 64'd0, 64'd1);
    tick();
    byte_i_valid = 1'b0;
  endtask

  task automatic feed_guards();
    while (gq.size() > 0) send_guard(gq.pop_front());
  endtask

  task automatic feed_bytes();
    while (bq.size() > 0) begin
      send_byte(bq.pop_front());
      repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic start_job(input logic d, input int stop);
    int t = 0;
    ctrl_valid = 1'b1;
    is_diff_i = d;
    stop_addr_i = AW'(stop);
    @(negedge clk);
    while (!ctrl_ready && t < 300) begin @(negedge clk); t++; end
    if (!ctrl_ready) chk("start_timeout", 64'd0, 64'd1);
    tick();
    ctrl_valid = 1'b0;
  endtask

  task automatic wait_finish();
    int t = 0;
    @(negedge clk);
    while (!ctrl_finish && t < 500) begin @(negedge clk); t++; end
    if (!ctrl_finish) begin
      chk("finish_timeout", 64'd0, 64'd1);
    end else begin
      chk("finish_lat", 64'(cyc), 64'(last_hs + 1));
      chk("finish_ready", 64'(ctrl_ready), 64'd1);
      chk("finish_valid", 64'(data_o_valid), 64'd0);
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("finish_pulse", 64'(ctrl_finish), 64'd0);
    tick();
  endtask

  task automatic push_exp(input logic [47:0] d, input int a, input logic p);
    sb.push_back('{d: d, a: AW'(a), p: p});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl_ready"}, 64'(ctrl_ready), 64'd1);
    chk({tag, "_finish"}, 64'(ctrl_finish), 64'd0);
    chk({tag, "_grdy"}, 64'(guard_i_ready), 64'd0);
    chk({tag, "_brdy"}, 64'(byte_i_ready), 64'd0);
    chk({tag, "_data"}, 64'(data_o), 64'd0);
    chk({tag, "_addr"}, 64'(addr_o), 64'd0);
    chk({tag, "_part"}, 64'(part_o), 64'd0);
    chk({tag, "_valid"}, 64'(data_o_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fc;

    // {guard, bytes (b[0] sent first), byte count, expected lanes 5..0}
    tab[0] = '{6'b000001, 48'h0000_0000_00AA, 3'd1, 48'h00_00_00_00_00_AA};
    tab[1] = '{6'b110000, 48'h0000_0000_2211, 3'd2, 48'h11_22_00_00_00_00};
    tab[2] = '{6'b101010, 48'h0000_00C3_C2C1, 3'd3, 48'hC1_00_C2_00_C3_00};
    tab[3] = '{6'b000000, 48'h0000_0000_0000, 3'd0, 48'h00_00_00_00_00_00};
    tab[4] = '{6'b111111, 48'h1514_1312_1110, 3'd6, 48'h10_11_12_13_14_15};
    tab[5] = '{6'b010101, 48'h0000_0080_7F7E, 3'd3, 48'h00_7E_00_7F_00_80};
    ptab[0] = '{24'h5A_0F_F0, 48'h0F_00_00_0F_05_0A};
    ptab[1] = '{24'h54_76_98, 48'h09_08_07_06_05_04};

    @(negedge clk);
    chk_reset_vals("rst");
`ifdef FM_GUARD_DECODE_STAT_EN
    chk("rst_zcnt", 64'(zero_vec_cnt_o), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Plain job with 5-cycle backpressure on the first vector; a stray ctrl_valid must be ignored.
    push_exp(48'h12_00_00_00_00_34, 0, 1'b0);
    push_exp(48'h00_00_00_00_00_00, 1, 1'b0);
    gq.push_back(6'b100001); gq.push_back(6'b000000);
    bq.push_back(8'h12); bq.push_back(8'h34);
    data_o_ready = 1'b0;
    start_job(1'b0, 1);
    fork
      feed_guards();
      feed_bytes();
      begin
        int t = 0;
        @(negedge clk);
        while (!data_o_valid && t < 300) begin @(negedge clk); t++; end
        if (!data_o_valid) chk("bp_timeout", 64'd0, 64'd1);
        for (int k = 0; k < 5; k++) begin
          chk("bp_data", 64'(data_o), 64'h12_00_00_00_00_34);
          chk("bp_addr", 64'(addr_o), 64'd0);
          chk("bp_part", 64'(part_o), 64'd0);
          chk("bp_grdy", 64'(guard_i_ready), 64'd0);
          chk("bp_brdy", 64'(byte_i_ready), 64'd0);
          tick();
          if (k == 0) begin ctrl_valid = 1'b1; is_diff_i = 1'b1; stop_addr_i = '0; end
          if (k < 4) @(negedge clk);
        end
        ctrl_valid = 1'b0;
        data_o_ready = 1'b1;
      end
    join
    wait_finish();

    // Diff job, stop_addr 0: pass A then packed pass B.
    push_exp(48'h00_A7_00_00_00_00, 0, 1'b0);
    push_exp(48'h02_01_04_03_06_05, 0, 1'b1);
    gq.push_back(6'b010000);
    bq.push_back(8'hA7); bq.push_back(8'h21); bq.push_back(8'h43); bq.push_back(8'h65);
    start_job(1'b1, 0);
    fork feed_guards(); feed_bytes(); join
    wait_finish();

    // Table-driven plain job over all six records, with random byte gaps.
    gap_max = 1;
    for (int i = 0; i < 6; i++) begin
      gq.push_back(tab[i].g);
      for (int j = 0; j < int'(tab[i].nb); j++) bq.push_back(tab[i].b[j]);
      push_exp(tab[i].exp, i, 1'b0);
    end
    start_job(1'b0, 5);
    fork feed_guards(); feed_bytes(); join
    wait_finish();

    // Table-driven diff job, two addresses.
    for (int i = 0; i < 2; i++) begin
      gq.push_back(tab[i].g);
      for (int j = 0; j < int'(tab[i].nb); j++) bq.push_back(tab[i].b[j]);
      push_exp(tab[i].exp, i, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) bq.push_back(ptab[i].b[j]);
      push_exp(ptab[i].exp, i, 1'b1);
    end
    start_job(1'b1, 1);
    fork feed_guards(); feed_bytes(); join
    wait_finish();
    gap_max = 0;

    // Byte starvation inside a full guard: no vector until the sixth byte.
    push_exp(48'h01_02_03_04_05_06, 0, 1'b0);
    start_job(1'b0, 0);
    send_guard(6'b111111);
    for (int k = 0; k < 6; k++) begin
      send_byte(8'(k + 1));
      if (k < 5) begin
        repeat (3) begin
          @(negedge clk);
          chk("starve_novec", 64'(data_o_valid), 64'd0);
          tick();
        end
      end
    end
    @(negedge clk);
    chk("lat_byte", 64'(data_o_valid), 64'd1);
    wait_finish();

    // Zero guard: vector valid the cycle after the guard is accepted.
    push_exp(48'h0, 0, 1'b0);
    start_job(1'b0, 0);
    send_guard(6'b000000);
    @(negedge clk);
    chk("lat_guard", 64'(data_o_valid), 64'd1);
    wait_finish();

    // Reset in the middle of a byte run.
    start_job(1'b0, 0);
    send_guard(6'b001111);
    send_byte(8'h5A);
    send_byte(8'h5B);
    fc = fin_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rst_nofin", 64'(fin_cnt), 64'(fc));

    push_exp(48'h00_00_00_00_77_00, 0, 1'b0);
    gq.push_back(6'b000010);
    bq.push_back(8'h77);
    start_job(1'b0, 0);
    fork feed_guards(); feed_bytes(); join
    wait_finish();

`ifdef FM_GUARD_DECODE_STAT_EN
    push_exp(48'h0, 0, 1'b0);
    push_exp(48'h00_00_00_55_00_00, 1, 1'b0);
    push_exp(48'h0, 2, 1'b0);
    push_exp(48'h0, 3, 1'b0);
    gq.push_back(6'b000000); gq.push_back(6'b000100);
    gq.push_back(6'b000000); gq.push_back(6'b000000);
    bq.push_back(8'h55);
    start_job(1'b0, 3);
    fork feed_guards(); feed_bytes(); join
    wait_finish();
    chk("zcnt_after", 64'(zero_vec_cnt_o), 64'd3);
    push_exp(48'h0, 0, 1'b0);
    start_job(1'b0, 0);
    @(negedge clk);
    chk("zcnt_clear", 64'(zero_vec_cnt_o), 64'd0);
    tick();
    send_guard(6'b000000);
    wait_finish();
    chk("zcnt_one", 64'(zero_vec_cnt_o), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
